vga_layer_compositor: RTL and testbench

- Parametrised multi-layer pixel compositor for the text/sprite VGA pipeline.
- Takes N sprite-layer palette indices per pixel and selects the highest-priority opaque layer.
- Colours are looked up in a software-writable, double-buffered palette; the palette commits only at the vsync edge, so frames never tear.
- Sits between the vga_controller/sprite RAMs and the VGA pins, behind the Avalon-MM slave of the display IP. It replaces the fixed-priority, hard-coded-palette colour mux.

---
 rtl/vga_comp_pkg.sv | 53 +++++
 rtl/vga_palette_dbuf.sv | 82 ++++++++
 rtl/vga_layer_compositor.sv | 220 ++++++++++++++++++++++
 tb/tb_vga_layer_compositor.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_comp_pkg.sv
// vga_comp_pkg
//   Shared definitions for the layer compositor: register offsets (relative
//   to NUM_COLORS, i.e. just above the palette window), CTRL bit positions
//   and helpers to pack/unpack a {R,G,B} palette word.
//   The helpers work on a widened word (MAX_COLOR_W per channel) so they can
//   serve any COLOR_W up to MAX_COLOR_W; callers cast to their own width.
package vga_comp_pkg;

    // Register word offsets above the palette window.
    localparam int REG_LAYER_EN = 0;
    localparam int REG_TRANSP   = 1;
    localparam int REG_BKG      = 2;
    localparam int REG_CTRL     = 3;
    localparam int NUM_REGS     = 4;

    // CTRL register bits.
    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_FRAME_BIT  = 1;

    localparam int MAX_COLOR_W = 16;

    typedef logic [3*MAX_COLOR_W-1:0] rgb_wide_t;
    typedef logic [MAX_COLOR_W-1:0]   chan_wide_t;

    // Channel position inside a packed {R,G,B} word, counted from the LSB.
    typedef enum logic [1:0] {
        CH_BLUE  = 2'd0,
        CH_GREEN = 2'd1,
        CH_RED   = 2'd2
    } chan_e;

    function automatic rgb_wide_t pack_rgb(input chan_wide_t r,
                                           input chan_wide_t g,
                                           input chan_wide_t b,
                                           input int unsigned cw);
        rgb_wide_t mask;
        mask = (rgb_wide_t'(1) << cw) - rgb_wide_t'(1);
        return ((rgb_wide_t'(r) & mask) << (2 * cw))
             | ((rgb_wide_t'(g) & mask) << cw)
             |  (rgb_wide_t'(b) & mask);
    endfunction

    function automatic chan_wide_t unpack_chan(input rgb_wide_t   rgb,
                                               input int unsigned cw,
                                               input chan_e       ch);
        rgb_wide_t mask;
        rgb_wide_t shifted;
        mask    = (rgb_wide_t'(1) << cw) - rgb_wide_t'(1);
        shifted = (rgb >> (32'(ch) * cw)) & mask;
        return shifted[MAX_COLOR_W-1:0];
    endfunction

endpackage

// File: rtl/vga_palette_dbuf.sv
// vga_palette_dbuf
//   Double-buffered colour palette. Software writes land in the shadow copy;
//   the active copy (used by the pixel path) is refreshed from the shadow in
//   a single cycle at the vsync edge, but only when a commit is pending.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   wr_en_i/idx/data       shadow write port
//   vs_edge_i              one-cycle pulse at the falling edge of vsync
//   pend_set_i             request a commit at the next vsync edge
//   commit_pend_o          commit request still outstanding
//   shadow_rd_idx/data     combinational read of the shadow copy
//   active_rd_idx/data     combinational read of the active copy
module vga_palette_dbuf
    import vga_comp_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int ENTRY_W = 12
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               wr_en_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic [ENTRY_W-1:0] wr_data_i,
    input  logic               vs_edge_i,
    input  logic               pend_set_i,
    output logic               commit_pend_o,
    input  logic [IDX_W-1:0]   shadow_rd_idx_i,
    output logic [ENTRY_W-1:0] shadow_rd_data_o,
    input  logic [IDX_W-1:0]   active_rd_idx_i,
    output logic [ENTRY_W-1:0] active_rd_data_o
);

    localparam int NUM_COLORS = 2 ** IDX_W;

    logic [ENTRY_W-1:0] shadow_q [NUM_COLORS];
    logic [ENTRY_W-1:0] active_q [NUM_COLORS];
    logic               pend_q;
    logic               pend_d;
    logic               do_commit;

    assign do_commit = vs_edge_i & pend_q;

    // A new request in the commit cycle wins, so it is not lost; it will be
    // served at the following vsync edge.
    always_comb begin
        pend_d = pend_q;
        if (do_commit) begin
            pend_d = 1'b0;
        end
        if (pend_set_i) begin
            pend_d = 1'b1;
        end
    end

    // The copy reads shadow_q before this edge's write lands, so a palette
    // write in the commit cycle only reaches the shadow.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_COLORS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (wr_en_i) begin
                shadow_q[wr_idx_i] <= wr_data_i;
            end
            if (do_commit) begin
                for (int i = 0; i < NUM_COLORS; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign commit_pend_o    = pend_q;
    assign shadow_rd_data_o = shadow_q[shadow_rd_idx_i];
    assign active_rd_data_o = active_q[active_rd_idx_i];

endmodule

// File: rtl/vga_layer_compositor.sv
// vga_layer_compositor
//   Picks the highest-priority opaque, enabled sprite layer for each pixel,
//   looks its colour up in a double-buffered palette and drives the VGA pins.
//   Layer 0 has the highest priority; no qualifying layer gives BKG.
//
// Ports
//   CLK, RESET_N              clock, synchronous active-low reset
//   AVL_*                     Avalon-MM slave (palette + control registers)
//   PIX_CE                    pixel strobe; the 3-stage pixel pipe advances on it
//   DISP_EN, HS_IN, VS_IN     blank and active-low syncs from the controller
//   LAYER_ON, LAYER_IDX       per-layer coverage and palette index
//   red, green, blue, hs, vs  pixel colour and syncs, all registered
//
// Avalon handshake: no wait states. A write is accepted on any edge with
// AVL_CS & AVL_WRITE; a read issued with AVL_CS & AVL_READ returns
// AVL_READDATA one cycle later, which then holds until the next read.
module vga_layer_compositor
    import vga_comp_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int IDX_W      = 4,
    parameter int COLOR_W    = 4,
    parameter int AVL_ADDR_W = 6,
    parameter int AVL_DATA_W = 16
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic                        AVL_CS,
    input  logic                        AVL_READ,
    input  logic                        AVL_WRITE,
    input  logic [AVL_ADDR_W-1:0]       AVL_ADDR,
    input  logic [AVL_DATA_W-1:0]       AVL_WRITEDATA,
    output logic [AVL_DATA_W-1:0]       AVL_READDATA,
    input  logic                        PIX_CE,
    input  logic                        DISP_EN,
    input  logic                        HS_IN,
    input  logic                        VS_IN,
    input  logic [NUM_LAYERS-1:0]       LAYER_ON,
    input  logic [NUM_LAYERS*IDX_W-1:0] LAYER_IDX,
    output logic [COLOR_W-1:0]          red,
    output logic [COLOR_W-1:0]          green,
    output logic [COLOR_W-1:0]          blue,
    output logic                        hs,
    output logic                        vs
);

    localparam int NUM_COLORS = 2 ** IDX_W;
    localparam int ENTRY_W    = 3 * COLOR_W;

    localparam logic [AVL_ADDR_W-1:0] ADDR_PAL_END  = AVL_ADDR_W'(NUM_COLORS);
    localparam logic [AVL_ADDR_W-1:0] ADDR_LAYER_EN = AVL_ADDR_W'(NUM_COLORS + REG_LAYER_EN);
    localparam logic [AVL_ADDR_W-1:0] ADDR_TRANSP   = AVL_ADDR_W'(NUM_COLORS + REG_TRANSP);
    localparam logic [AVL_ADDR_W-1:0] ADDR_BKG      = AVL_ADDR_W'(NUM_COLORS + REG_BKG);
    localparam logic [AVL_ADDR_W-1:0] ADDR_CTRL     = AVL_ADDR_W'(NUM_COLORS + REG_CTRL);

    // ---------------- Avalon register block ----------------
    logic                  avl_wr;
    logic                  avl_rd;
    logic                  addr_is_pal;
    logic                  pal_wr;
    logic                  pend_set;
    logic                  commit_pend;
    logic                  vs_edge;
    logic [ENTRY_W-1:0]    shadow_rd_data;
    logic [ENTRY_W-1:0]    active_rd_data;
    logic [AVL_DATA_W-1:0] rdata_d;
    logic                  unused_wdata;

    logic [NUM_LAYERS-1:0] layer_en_q;
    logic [IDX_W-1:0]      transp_q;
    logic [ENTRY_W-1:0]    bkg_q;
    logic                  frame_q;
    logic                  vs_prev_q;
    logic [AVL_DATA_W-1:0] rdata_q;

    assign avl_wr      = AVL_CS & AVL_WRITE;
    assign avl_rd      = AVL_CS & AVL_READ;
    assign addr_is_pal = (AVL_ADDR < ADDR_PAL_END);
    assign pal_wr      = avl_wr & addr_is_pal;
    assign pend_set    = avl_wr & (AVL_ADDR == ADDR_CTRL) & AVL_WRITEDATA[CTRL_COMMIT_BIT];
    assign vs_edge     = vs_prev_q & ~VS_IN;
    // Upper write-data bits are ignored by every register.
    assign unused_wdata = ^AVL_WRITEDATA;

    always_comb begin
        rdata_d = '0;
        if (addr_is_pal) begin
            rdata_d = AVL_DATA_W'(shadow_rd_data);
        end else if (AVL_ADDR == ADDR_LAYER_EN) begin
            rdata_d = AVL_DATA_W'(layer_en_q);
        end else if (AVL_ADDR == ADDR_TRANSP) begin
            rdata_d = AVL_DATA_W'(transp_q);
        end else if (AVL_ADDR == ADDR_BKG) begin
            rdata_d = AVL_DATA_W'(bkg_q);
        end else if (AVL_ADDR == ADDR_CTRL) begin
            rdata_d[CTRL_COMMIT_BIT] = commit_pend;
            rdata_d[CTRL_FRAME_BIT]  = frame_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            layer_en_q <= '1;
            transp_q   <= '1;
            bkg_q      <= '0;
            frame_q    <= 1'b0;
            vs_prev_q  <= 1'b1;
            rdata_q    <= '0;
        end else begin
            vs_prev_q <= VS_IN;
            if (vs_edge) begin
                frame_q <= ~frame_q;
            end
            if (avl_wr) begin
                if (AVL_ADDR == ADDR_LAYER_EN) begin
                    layer_en_q <= AVL_WRITEDATA[NUM_LAYERS-1:0];
                end
                if (AVL_ADDR == ADDR_TRANSP) begin
                    transp_q <= AVL_WRITEDATA[IDX_W-1:0];
                end
                if (AVL_ADDR == ADDR_BKG) begin
                    bkg_q <= AVL_WRITEDATA[ENTRY_W-1:0];
                end
            end
            if (avl_rd) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign AVL_READDATA = rdata_q;

    // ---------------- Palette ----------------
    logic [IDX_W-1:0] s1_idx_q;

    vga_palette_dbuf #(
        .IDX_W   (IDX_W),
        .ENTRY_W (ENTRY_W)
    ) u_palette (
        .clk_i            (CLK),
        .rst_ni           (RESET_N),
        .wr_en_i          (pal_wr),
        .wr_idx_i         (AVL_ADDR[IDX_W-1:0]),
        .wr_data_i        (AVL_WRITEDATA[ENTRY_W-1:0]),
        .vs_edge_i        (vs_edge),
        .pend_set_i       (pend_set),
        .commit_pend_o    (commit_pend),
        .shadow_rd_idx_i  (AVL_ADDR[IDX_W-1:0]),
        .shadow_rd_data_o (shadow_rd_data),
        .active_rd_idx_i  (s1_idx_q),
        .active_rd_data_o (active_rd_data)
    );

    // ---------------- Pixel pipeline ----------------
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic [ENTRY_W-1:0] out_rgb;

    logic               s1_valid_q, s1_disp_q, s1_hs_q, s1_vs_q;
    logic [ENTRY_W-1:0] s2_colour_q;
    logic               s2_disp_q, s2_hs_q, s2_vs_q;
    logic [COLOR_W-1:0] red_q, green_q, blue_q;
    logic               hs_q, vs_q;

    // Scan from the lowest priority upward so the last hit (lowest k) wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (LAYER_ON[k] && layer_en_q[k] &&
                (LAYER_IDX[k*IDX_W +: IDX_W] != transp_q)) begin
                sel_valid = 1'b1;
                sel_idx   = LAYER_IDX[k*IDX_W +: IDX_W];
            end
        end
    end

    assign out_rgb = s2_disp_q ? s2_colour_q : '0;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            s1_idx_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_disp_q   <= 1'b0;
            s1_hs_q     <= 1'b1;
            s1_vs_q     <= 1'b1;
            s2_colour_q <= '0;
            s2_disp_q   <= 1'b0;
            s2_hs_q     <= 1'b1;
            s2_vs_q     <= 1'b1;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
        end else if (PIX_CE) begin
            s1_idx_q    <= sel_idx;
            s1_valid_q  <= sel_valid;
            s1_disp_q   <= DISP_EN;
            s1_hs_q     <= HS_IN;
            s1_vs_q     <= VS_IN;
            s2_colour_q <= s1_valid_q ? active_rd_data : bkg_q;
            s2_disp_q   <= s1_disp_q;
            s2_hs_q     <= s1_hs_q;
            s2_vs_q     <= s1_vs_q;
            red_q       <= COLOR_W'(unpack_chan(rgb_wide_t'(out_rgb), COLOR_W, CH_RED));
            green_q     <= COLOR_W'(unpack_chan(rgb_wide_t'(out_rgb), COLOR_W, CH_GREEN));
            blue_q      <= COLOR_W'(unpack_chan(rgb_wide_t'(out_rgb), COLOR_W, CH_BLUE));
            hs_q        <= s2_hs_q;
            vs_q        <= s2_vs_q;
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;
    assign hs    = hs_q;
    assign vs    = vs_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
module tb_vga_layer_compositor;

    localparam int NL = 4;
    localparam int IW = 4;
    localparam int CW = 4;
    localparam int AW = 6;
    localparam int DW = 16;
    localparam int NC = 16;
    localparam int A_LEN  = NC + 0;
    localparam int A_TR   = NC + 1;
    localparam int A_BKG  = NC + 2;
    localparam int A_CTRL = NC + 3;

    // ---------------- clock / reset / DUT ----------------
    logic            CLK = 1'b0;
    logic            RESET_N = 1'b0;
    logic            AVL_CS = 1'b0;
    logic            AVL_READ = 1'b0;
    logic            AVL_WRITE = 1'b0;
    logic [AW-1:0]   AVL_ADDR = '0;
    logic [DW-1:0]   AVL_WRITEDATA = '0;
    logic [DW-1:0]   AVL_READDATA;
    logic            PIX_CE = 1'b0;
    logic            DISP_EN = 1'b0;
    logic            HS_IN = 1'b1;
    logic            VS_IN = 1'b1;
    logic [NL-1:0]   LAYER_ON = '0;
    logic [NL*IW-1:0] LAYER_IDX = '0;
    logic [CW-1:0]   red, green, blue;
    logic            hs, vs;

    logic [3*CW-1:0] rgb;
    logic [3*CW+1:0] rgbs;
    assign rgb  = {red, green, blue};
    assign rgbs = {red, green, blue, hs, vs};

    always #10 CLK = ~CLK;

    vga_layer_compositor #(
        .NUM_LAYERS (NL),
        .IDX_W      (IW),
        .COLOR_W    (CW),
        .AVL_ADDR_W (AW),
        .AVL_DATA_W (DW)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .AVL_CS        (AVL_CS),
        .AVL_READ      (AVL_READ),
        .AVL_WRITE     (AVL_WRITE),
        .AVL_ADDR      (AVL_ADDR),
        .AVL_WRITEDATA (AVL_WRITEDATA),
        .AVL_READDATA  (AVL_READDATA),
        .PIX_CE        (PIX_CE),
        .DISP_EN       (DISP_EN),
        .HS_IN         (HS_IN),
        .VS_IN         (VS_IN),
        .LAYER_ON      (LAYER_ON),
        .LAYER_IDX     (LAYER_IDX),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .hs            (hs),
        .vs            (vs)
    );

    int            pass_cnt = 0;
    int            total_cnt = 0;
    logic          exp_frame = 1'b0;
    logic [DW-1:0] rd;

    // ---------------- driver tasks (start and end at a negedge) ----------------
    task automatic avl_write(input int addr, input logic [DW-1:0] data);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = AW'(addr); AVL_WRITEDATA = data;
        @(negedge CLK);
        AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    endtask

    task automatic avl_read(input int addr, output logic [DW-1:0] data);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = AW'(addr);
        @(negedge CLK);
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        data = AVL_READDATA;
    endtask

    task automatic strobe(input int n);
        PIX_CE = 1'b1;
        repeat (n) @(negedge CLK);
        PIX_CE = 1'b0;
    endtask

    task automatic vsync_pulse();
        VS_IN = 1'b0;
        @(negedge CLK);
        VS_IN = 1'b1;
        exp_frame = ~exp_frame;
        @(negedge CLK);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESET_N = 1'b0;
        // A write and pixel strobe during reset must be overridden.
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = AW'(A_BKG); AVL_WRITEDATA = 16'h0FFF;
        PIX_CE = 1'b1; DISP_EN = 1'b1;
        repeat (2) @(negedge CLK);
        total_cnt++;
        if (rgbs !== 14'b0000_0000_0000_11) $display("FAIL reset_pins: rgb/hs/vs=%h required %h", rgbs, 14'b0000_0000_0000_11);
        else pass_cnt++;
        total_cnt++;
        if (AVL_READDATA !== 16'h0000) $display("FAIL reset_readdata: got %h required 0000", AVL_READDATA);
        else pass_cnt++;
        AVL_CS = 1'b0; AVL_WRITE = 1'b0; PIX_CE = 1'b0; DISP_EN = 1'b0;
        RESET_N = 1'b1;
        @(negedge CLK);
        avl_read(A_CTRL, rd);
        total_cnt++;
        if (rd !== 16'h0000) $display("FAIL reset_ctrl: got %h required 0000", rd); else pass_cnt++;
        avl_read(A_LEN, rd);
        total_cnt++;
        if (rd !== 16'h000F) $display("FAIL reset_layer_en: got %h required 000f", rd); else pass_cnt++;
        avl_read(A_TR, rd);
        total_cnt++;
        if (rd !== 16'h000F) $display("FAIL reset_transp: got %h required 000f", rd); else pass_cnt++;
        avl_read(A_BKG, rd);
        total_cnt++;
        if (rd !== 16'h0000) $display("FAIL reset_bkg_write_blocked: got %h required 0000", rd); else pass_cnt++;
        avl_read(3, rd);
        total_cnt++;
        if (rd !== 16'h0000) $display("FAIL reset_palette: got %h required 0000", rd); else pass_cnt++;
    endtask

    task automatic test_regmap();
        avl_write(1, 16'hFFFF);
        avl_read(1, rd);
        total_cnt++;
        if (rd !== 16'h0FFF) $display("FAIL pal_upper_bits: got %h required 0fff", rd); else pass_cnt++;
        avl_write(A_LEN, 16'hFFF5);
        avl_read(A_LEN, rd);
        total_cnt++;
        if (rd !== 16'h0005) $display("FAIL layer_en_rw: got %h required 0005", rd); else pass_cnt++;
        avl_write(A_LEN, 16'h000F);
        avl_read(NC + 4, rd);
        total_cnt++;
        if (rd !== 16'h0000) $display("FAIL unmapped_read_20: got %h required 0000", rd); else pass_cnt++;
        avl_write(63, 16'hFFFF);
        avl_read(63, rd);
        total_cnt++;
        if (rd !== 16'h0000) $display("FAIL unmapped_read_63: got %h required 0000", rd); else pass_cnt++;
        avl_read(A_BKG, rd);
        total_cnt++;
        if (rd !== 16'h0000) $display("FAIL unmapped_write_ignored: bkg=%h required 0000", rd); else pass_cnt++;
        avl_read(A_TR, rd);
        repeat (3) @(negedge CLK);
        total_cnt++;
        if (AVL_READDATA !== 16'h000F) $display("FAIL readdata_hold: got %h required 000f", AVL_READDATA); else pass_cnt++;
    endtask

    task automatic test_commit();
        avl_write(3, 16'h0F00);
        avl_write(A_CTRL, 16'h0001);
        avl_write(A_CTRL, 16'h0000);
        avl_read(A_CTRL, rd);
        total_cnt++;
        if (rd !== 16'h0001) $display("FAIL ctrl_write0_no_clear: got %h required 0001", rd); else pass_cnt++;
        LAYER_ON = 4'b0001; LAYER_IDX = 16'h0003; DISP_EN = 1'b1;
        strobe(3);
        total_cnt++;
        if (rgb !== 12'h000) $display("FAIL commit_before_vsync: rgb=%h required 000", rgb); else pass_cnt++;
        vsync_pulse();
        strobe(3);
        total_cnt++;
        if (rgb !== 12'hF00) $display("FAIL commit_after_vsync: rgb=%h required f00", rgb); else pass_cnt++;
        avl_read(A_CTRL, rd);
        total_cnt++;
        if (rd !== 16'h0002) $display("FAIL commit_ctrl: got %h required 0002", rd); else pass_cnt++;
        // No commit pending: vsync must leave the active palette alone.
        avl_write(3, 16'h000F);
        vsync_pulse();
        strobe(3);
        total_cnt++;
        if (rgb !== 12'hF00) $display("FAIL no_pend_no_copy: rgb=%h required f00", rgb); else pass_cnt++;
        avl_read(3, rd);
        total_cnt++;
        if (rd !== 16'h000F) $display("FAIL shadow_readback: got %h required 000f", rd); else pass_cnt++;
        avl_read(A_CTRL, rd);
        total_cnt++;
        if (rd !== {14'b0, exp_frame, 1'b0}) $display("FAIL frame_toggle: got %h required %h", rd, {14'b0, exp_frame, 1'b0}); else pass_cnt++;
    endtask

    task automatic test_priority();
        avl_write(2, 16'h00A0);
        avl_write(5, 16'h0005);
        avl_write(15, 16'h0777);
        avl_write(A_CTRL, 16'h0001);
        vsync_pulse();
        LAYER_ON = 4'b1111; LAYER_IDX = 16'h752F; DISP_EN = 1'b1;
        strobe(3);
        total_cnt++;
        if (rgb !== 12'h0A0) $display("FAIL prio_transp_skip: rgb=%h required 0a0", rgb); else pass_cnt++;
        avl_write(A_LEN, 16'h000D);
        strobe(3);
        total_cnt++;
        if (rgb !== 12'h005) $display("FAIL prio_layer_disabled: rgb=%h required 005", rgb); else pass_cnt++;
        avl_write(A_TR, 16'h0002);
        strobe(3);
        total_cnt++;
        if (rgb !== 12'h777) $display("FAIL prio_transp_reg: rgb=%h required 777", rgb); else pass_cnt++;
        avl_write(A_TR, 16'h000F);
        avl_write(A_LEN, 16'h000F);
        LAYER_ON = 4'b1100;
        strobe(3);
        total_cnt++;
        if (rgb !== 12'h005) $display("FAIL prio_layer_on_gate: rgb=%h required 005", rgb); else pass_cnt++;
    endtask

    task automatic test_background();
        avl_write(A_BKG, 16'h0123);
        LAYER_ON = 4'b0000; DISP_EN = 1'b1;
        strobe(3);
        total_cnt++;
        if (rgb !== 12'h123) $display("FAIL bkg_all_off: rgb=%h required 123", rgb); else pass_cnt++;
        LAYER_ON = 4'b1111;
        avl_write(A_LEN, 16'h0000);
        strobe(3);
        total_cnt++;
        if (rgb !== 12'h123) $display("FAIL bkg_all_disabled: rgb=%h required 123", rgb); else pass_cnt++;
        avl_write(A_LEN, 16'h000F);
        LAYER_IDX = 16'hFFFF;
        strobe(3);
        total_cnt++;
        if (rgb !== 12'h123) $display("FAIL bkg_all_transp: rgb=%h required 123", rgb); else pass_cnt++;
        DISP_EN = 1'b0;
        strobe(2);
        total_cnt++;
        if (rgb !== 12'h123) $display("FAIL blank_latency_2: rgb=%h required 123", rgb); else pass_cnt++;
        strobe(1);
        total_cnt++;
        if (rgb !== 12'h000) $display("FAIL blank_latency_3: rgb=%h required 000", rgb); else pass_cnt++;
        DISP_EN = 1'b1; LAYER_ON = 4'b0000;
    endtask

    task automatic test_stall();
        strobe(3);
        total_cnt++;
        if (rgbs !== {12'h123, 2'b11}) $display("FAIL stall_pre: got %h required %h", rgbs, {12'h123, 2'b11}); else pass_cnt++;
        // Pixel A: blanked, both syncs asserted.
        DISP_EN = 1'b0; HS_IN = 1'b0; VS_IN = 1'b0;
        strobe(1);
        exp_frame = ~exp_frame;
        DISP_EN = 1'b1; HS_IN = 1'b1; VS_IN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            DISP_EN = i[0]; HS_IN = ~i[0];
            @(negedge CLK);
            total_cnt++;
            if (rgbs !== {12'h123, 2'b11}) $display("FAIL stall_hold_a_%0d: got %h required %h", i, rgbs, {12'h123, 2'b11}); else pass_cnt++;
        end
        DISP_EN = 1'b1; HS_IN = 1'b1;
        strobe(1);
        total_cnt++;
        if (rgbs !== {12'h123, 2'b11}) $display("FAIL stall_strobe_n1: got %h required %h", rgbs, {12'h123, 2'b11}); else pass_cnt++;
        strobe(1);
        total_cnt++;
        if (rgbs !== 14'h0000) $display("FAIL stall_strobe_n2: got %h required 0000", rgbs); else pass_cnt++;
        repeat (5) @(negedge CLK);
        total_cnt++;
        if (rgbs !== 14'h0000) $display("FAIL stall_hold_out: got %h required 0000", rgbs); else pass_cnt++;
        strobe(1);
        total_cnt++;
        if (rgbs !== {12'h123, 2'b11}) $display("FAIL stall_resume: got %h required %h", rgbs, {12'h123, 2'b11}); else pass_cnt++;
        avl_read(A_CTRL, rd);
        total_cnt++;
        if (rd !== {14'b0, exp_frame, 1'b0}) $display("FAIL stall_frame: got %h required %h", rd, {14'b0, exp_frame, 1'b0}); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        LAYER_ON = 4'b0001; LAYER_IDX = 16'h0003; DISP_EN = 1'b1;
        avl_write(3, 16'h0050);
        avl_write(A_CTRL, 16'h0001);
        vsync_pulse();
        strobe(3);
        total_cnt++;
        if (rgb !== 12'h050) $display("FAIL sim_setup: rgb=%h required 050", rgb); else pass_cnt++;
        // Palette write in the commit cycle.
        avl_write(A_CTRL, 16'h0001);
        VS_IN = 1'b0;
        avl_write(3, 16'h0A0A);
        VS_IN = 1'b1; exp_frame = ~exp_frame;
        @(negedge CLK);
        strobe(3);
        total_cnt++;
        if (rgb !== 12'h050) $display("FAIL sim_wr_active_old: rgb=%h required 050", rgb); else pass_cnt++;
        avl_read(3, rd);
        total_cnt++;
        if (rd !== 16'h0A0A) $display("FAIL sim_wr_shadow_new: got %h required 0a0a", rd); else pass_cnt++;
        avl_read(A_CTRL, rd);
        total_cnt++;
        if (rd !== {14'b0, exp_frame, 1'b0}) $display("FAIL sim_wr_ctrl: got %h required %h", rd, {14'b0, exp_frame, 1'b0}); else pass_cnt++;
        // Commit request in the vsync cycle with nothing pending: waits a frame.
        VS_IN = 1'b0;
        avl_write(A_CTRL, 16'h0001);
        VS_IN = 1'b1; exp_frame = ~exp_frame;
        @(negedge CLK);
        strobe(3);
        total_cnt++;
        if (rgb !== 12'h050) $display("FAIL sim_pend_new_no_copy: rgb=%h required 050", rgb); else pass_cnt++;
        avl_read(A_CTRL, rd);
        total_cnt++;
        if (rd !== {14'b0, exp_frame, 1'b1}) $display("FAIL sim_pend_new_ctrl: got %h required %h", rd, {14'b0, exp_frame, 1'b1}); else pass_cnt++;
        vsync_pulse();
        strobe(3);
        total_cnt++;
        if (rgb !== 12'hA0A) $display("FAIL sim_next_frame_copy: rgb=%h required a0a", rgb); else pass_cnt++;
        // Commit request in the vsync cycle while already pending: copy and stay pending.
        avl_write(A_CTRL, 16'h0001);
        avl_write(3, 16'h0111);
        VS_IN = 1'b0;
        avl_write(A_CTRL, 16'h0001);
        VS_IN = 1'b1; exp_frame = ~exp_frame;
        @(negedge CLK);
        strobe(3);
        total_cnt++;
        if (rgb !== 12'h111) $display("FAIL sim_pend_both_copy: rgb=%h required 111", rgb); else pass_cnt++;
        avl_read(A_CTRL, rd);
        total_cnt++;
        if (rd !== {14'b0, exp_frame, 1'b1}) $display("FAIL sim_pend_both_ctrl: got %h required %h", rd, {14'b0, exp_frame, 1'b1}); else pass_cnt++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(negedge CLK);
        test_reset();
        test_regmap();
        test_commit();
        test_priority();
        test_background();
        test_stall();
        test_simultaneous();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
